// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream mux, manual select or round-robin arbitration,
// with a single registered output stage.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  rr_ch, idx, chosen;
  logic              rr_found, found, load, xfer;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_data[i]  = in_data[i*DATA_W +: DATA_W];
    assign in_ready[i] = !rst && load && found && (chosen == SEL_W'(i));
  end

  // Scan starts one past the last grant so every valid channel is served in turn.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = SEL_W'((32'(last_grant_q) + k) % NUM_CH);
      if (!rr_found && in_valid[idx]) begin
        rr_found = 1'b1;
        rr_ch    = idx;
      end
    end
  end

  always_comb begin
    chosen       = mode ? rr_ch : sel;
    found        = mode ? rr_found : (32'(sel) < NUM_CH);
    load         = !out_valid_q || out_ready;
    xfer         = |(in_ready & in_valid);
    out_valid_d  = load ? xfer : out_valid_q;
    out_data_d   = xfer ? ch_data[chosen] : out_data_q;
    out_ch_d     = xfer ? chosen : out_ch_q;
    last_grant_d = (xfer && mode) ? chosen : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule
